string_to_board: RTL and testbench

Inverse of the board-to-text printer. Accepts a stream of ASCII characters, one per strobe, and parses 16 decimal tile values plus one decimal score. On a complete frame it commits the values to a packed 320-bit board and a 21-bit score. It sits between the character source (UART receive path or a loopback from the printer's char_out) and the game-state register file. It is used to load saved or test positions and to self-check the printer.

---
 rtl/s2b_pkg.sv | 34 +++
 rtl/dec_accum.sv | 56 +++++
 rtl/string_to_board.sv | 163 ++++++++++++++++
 tb/tb_string_to_board.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2b_pkg.sv
// s2b_pkg: shared constants, ASCII codes and FSM state type for the
// string_to_board text-to-board parser.
//
// Contents:
//   NUM_TILES, TILE_W, SCORE_W  frame geometry
//   ACC_W                        accumulator width (score width plus 4 so that
//                                acc*10+9 never wraps before the clamp check)
//   TILE_MAX, SCORE_MAX          saturation limits at accumulator width
//   ASCII_0, ASCII_9, ASCII_ESC  character codes of interest
//   state_t                      parser FSM states
package s2b_pkg;

    localparam int NUM_TILES = 16;
    localparam int TILE_W    = 20;
    localparam int SCORE_W   = 21;
    localparam int ACC_W     = SCORE_W + 4;
    // Field index runs 0..NUM_TILES (the last value selects the score field).
    localparam int IDX_W     = 5;

    localparam logic [ACC_W-1:0] TILE_MAX  = {{(ACC_W-TILE_W){1'b0}}, {TILE_W{1'b1}}};
    localparam logic [ACC_W-1:0] SCORE_MAX = {{(ACC_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/dec_accum.sv
// dec_accum: saturating decimal accumulator.
//
// Each digit_valid cycle folds one decimal digit in: acc = acc*10 + digit.
// When the result would exceed max_val, acc is clamped to max_val and then
// held there for the rest of the field; the accumulator never wraps.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          clears acc and the clamp flag (wins over digit_valid)
//   digit_valid  fold digit into acc this cycle
//   digit        decimal digit 0..9
//   max_val      saturation limit for the field currently being parsed
//   acc          accumulated value
//   sat          combinational pulse on the cycle the clamp first occurs
module dec_accum
    import s2b_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic [ACC_W-1:0] max_val,
    output logic [ACC_W-1:0] acc,
    output logic             sat
);

    logic             clamped;
    logic [ACC_W-1:0] next_val;
    logic             over;

    always_comb begin
        next_val = acc * ACC_W'(10) + ACC_W'(digit);
        over     = next_val > max_val;
        // Only the first clamp of a field reports; later digits just hold.
        sat      = digit_valid && !clr && over && !clamped;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            clamped <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            clamped <= 1'b0;
        end else if (digit_valid && !clamped) begin
            if (over) begin
                acc     <= max_val;
                clamped <= 1'b1;
            end else begin
                acc <= next_val;
            end
        end
    end

endmodule

// File: rtl/string_to_board.sv
// string_to_board: parses an ASCII stream of 16 decimal tile values followed
// by one decimal score and commits them to a packed board and score register.
//
// Input strobe: char_valid is a one-cycle qualifier for char_in. There is no
// backpressure; every char_valid seen in RECV is consumed in that cycle.
// Characters outside RECV are dropped. start always wins over char_valid.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       arm the parser, discarding any partial frame (IDLE/RECV only)
//   char_in     ASCII character
//   char_valid  char_in qualifier
//   board       committed board, tile i at [i*TILE_W +: TILE_W]
//   score       committed score
//   busy        high while parsing (RECV)
//   done        one-cycle pulse on the cycle after commit
//   error       sticky saturation flag for the current/last frame
//   dbg_state   current FSM state
module string_to_board
    import s2b_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  char_in,
    input  logic                        char_valid,
    output logic [NUM_TILES*TILE_W-1:0] board,
    output logic [SCORE_W-1:0]          score,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output state_t                      dbg_state
);

    state_t state, state_next;

    logic [IDX_W-1:0]                   idx;
    logic                               seen;
    logic [NUM_TILES-1:0][TILE_W-1:0]   shadow;
    logic [SCORE_W-1:0]                 score_sh;
    logic [NUM_TILES-1:0][TILE_W-1:0]   board_q;
    logic [SCORE_W-1:0]                 score_q;
    logic                               error_q;

    logic             is_digit;
    logic             is_esc;
    logic             start_ok;
    logic             take;
    logic             close;
    logic             last_field;
    logic             acc_clr;
    logic             digit_valid;
    logic [ACC_W-1:0] max_val;
    logic [ACC_W-1:0] acc;
    logic             sat;
    logic             acc_hi_unused;

    always_comb begin
        is_digit    = (char_in >= ASCII_0) && (char_in <= ASCII_9);
        is_esc      = (char_in == ASCII_ESC);
        // start is ignored in COMMIT/DONE so a commit in flight always finishes.
        start_ok    = start && ((state == IDLE) || (state == RECV));
        take        = (state == RECV) && char_valid && !start;
        // A non-digit only closes a field after at least one digit, so runs of
        // separators never create empty fields.
        close       = take && !is_digit && !is_esc && seen;
        last_field  = (idx == IDX_W'(NUM_TILES));
        digit_valid = take && is_digit;
        acc_clr     = start_ok || close;
        max_val     = last_field ? SCORE_MAX : TILE_MAX;
    end

    dec_accum u_accum (
        .clk         (clk),
        .rst         (rst),
        .clr         (acc_clr),
        .digit_valid (digit_valid),
        .digit       (char_in[3:0]),
        .max_val     (max_val),
        .acc         (acc),
        .sat         (sat)
    );

    // acc is clamped to max_val, so bits above the score width are always zero.
    assign acc_hi_unused = ^acc[ACC_W-1:SCORE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RECV;
            end
            RECV: begin
                busy = 1'b1;
                if (start) begin
                    state_next = RECV;
                end else if (take && is_esc) begin
                    state_next = IDLE;
                end else if (close && last_field) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            seen     <= 1'b0;
            shadow   <= '0;
            score_sh <= '0;
            board_q  <= '0;
            score_q  <= '0;
            error_q  <= 1'b0;
        end else if (start_ok) begin
            idx      <= '0;
            seen     <= 1'b0;
            shadow   <= '0;
            score_sh <= '0;
            error_q  <= 1'b0;
        end else begin
            if (sat) error_q <= 1'b1;
            if (digit_valid) seen <= 1'b1;
            if (close) begin
                if (last_field) begin
                    score_sh <= acc[SCORE_W-1:0];
                end else begin
                    shadow[idx[3:0]] <= acc[TILE_W-1:0];
                end
                idx  <= idx + IDX_W'(1);
                seen <= 1'b0;
            end
            if (state == COMMIT) begin
                board_q <= shadow;
                score_q <= score_sh;
            end
        end
    end

    assign board     = board_q;
    assign score     = score_q;
    assign error     = error_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_string_to_board.sv
// tb_string_to_board: directed plus randomized frames for string_to_board.
// Expected board/score/error come from the integer field values of each frame
// (each field clamps to its maximum; error if any field exceeds it).
module tb_string_to_board;
    import s2b_pkg::*;

    localparam int BW   = NUM_TILES * TILE_W;
    localparam int TMAX = 1048575;
    localparam int SMAX = 2097151;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         char_in;
    logic               char_valid;
    logic [BW-1:0]      board;
    logic [SCORE_W-1:0] score;
    logic               busy;
    logic               done;
    logic               error;
    state_t             dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    logic [BW-1:0]      exp_board;
    logic [SCORE_W-1:0] exp_score;
    logic               exp_err;
    int                 v[17];

    string_to_board dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .char_in    (char_in),
        .char_valid (char_valid),
        .board      (board),
        .score      (score),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int fv[17]);
        int t;
        exp_board = '0;
        exp_err   = 1'b0;
        for (int i = 0; i < NUM_TILES; i++) begin
            t = fv[i];
            if (t > TMAX) begin
                t = TMAX;
                exp_err = 1'b1;
            end
            exp_board[i*TILE_W +: TILE_W] = t[TILE_W-1:0];
        end
        t = fv[16];
        if (t > SMAX) begin
            t = SMAX;
            exp_err = 1'b1;
        end
        exp_score = t[SCORE_W-1:0];
    endfunction

    function automatic int rand_val(input int lim);
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return int'($urandom_range(0, 999));
            6:       return int'($urandom_range(0, lim));
            7:       return int'($urandom_range(lim - 3, lim + 3));
            8:       return int'($urandom_range(0, 99999999));
            default: return 0;
        endcase
    endfunction

    task automatic send_char(input logic [7:0] c);
        char_in    = c;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        char_in    = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input int fv[17], input bit rnd);
        logic [7:0] sep;
        for (int f = 0; f < 17; f++) begin
            if (rnd) repeat ($urandom_range(0, 2)) send_char("0");
            send_str($sformatf("%0d", fv[f]));
            if (f < 16) begin
                repeat (rnd ? $urandom_range(1, 3) : 1) begin
                    sep = " ";
                    if (rnd) begin
                        case ($urandom_range(0, 3))
                            0: sep = " ";
                            1: sep = "|";
                            2: sep = 8'h0D;
                            default: sep = 8'h0A;
                        endcase
                    end
                    send_char(sep);
                end
            end else begin
                send_char(8'h0A);
            end
        end
    endtask

    // Called at the negedge right after the score terminator was sampled.
    task automatic expect_commit(input string tag);
        int cnt;
        cnt = done_cnt;
        check({tag, "/done_early"}, done, 1'b0);
        @(negedge clk);
        check({tag, "/done"},  done,  1'b1);
        check({tag, "/busy"},  busy,  1'b0);
        check({tag, "/board"}, board, exp_board);
        check({tag, "/score"}, score, exp_score);
        check({tag, "/error"}, error, exp_err);
        @(negedge clk);
        check({tag, "/done_end"}, done, 1'b0);
        check({tag, "/done_cnt"}, done_cnt - cnt, 1);
    endtask

    initial begin
        int cnt;
        rst        = 1'b1;
        start      = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        repeat (2) @(negedge clk);
        check("rst/board", board, '0);
        check("rst/score", score, '0);
        check("rst/busy",  busy,  1'b0);
        check("rst/done",  done,  1'b0);
        check("rst/error", error, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst/state", dbg_state, IDLE);

        // Characters in IDLE are ignored.
        send_str("12 3\n");
        check("idle/busy", busy, 1'b0);

        // Full frame with powers of two.
        v[0] = 0;
        for (int i = 1; i < 16; i++) v[i] = 1 << i;
        v[16] = 102444;
        pulse_start();
        check("full/busy", busy, 1'b1);
        send_frame(v, 1'b0);
        model(v);
        expect_commit("full");

        // Mixed separators; runs of '|' make no empty fields.
        pulse_start();
        send_str("|2||0|");
        repeat (15) send_str("|0");
        send_char("|");
        v = '{default: 0};
        v[0] = 2;
        model(v);
        expect_commit("mixed");

        // Tile overflow.
        v = '{default: 0};
        v[0] = 9999999;
        pulse_start();
        send_frame(v, 1'b0);
        model(v);
        expect_commit("ovf");
        pulse_start();
        check("ovf/err_clear", error, 1'b0);

        // Abort with ESC keeps the committed board.
        cnt = done_cnt;
        send_str("1 2 3 4 5 ");
        send_char(ASCII_ESC);
        check("abort/busy",  busy,  1'b0);
        check("abort/state", dbg_state, IDLE);
        check("abort/board", board, exp_board);
        check("abort/score", score, exp_score);
        repeat (3) @(negedge clk);
        check("abort/no_done", done_cnt - cnt, 0);

        // Exact maxima: no error.
        for (int i = 0; i < 16; i++) v[i] = int'($urandom_range(0, 500));
        v[3]  = TMAX;
        v[16] = SMAX;
        pulse_start();
        send_frame(v, 1'b1);
        model(v);
        expect_commit("exact_max");

        // One past maxima, including the score.
        v[5]  = TMAX + 1;
        v[16] = SMAX + 1;
        pulse_start();
        send_frame(v, 1'b1);
        model(v);
        expect_commit("past_max");

        // Restart mid-frame.
        pulse_start();
        send_str("7 8 9 12");
        pulse_start();
        for (int i = 0; i < 17; i++) v[i] = rand_val(i < 16 ? TMAX : SMAX);
        send_frame(v, 1'b1);
        model(v);
        expect_commit("restart");

        // start together with a digit: the digit is dropped.
        pulse_start();
        send_char("5");
        start      = 1'b1;
        char_in    = "7";
        char_valid = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        char_valid = 1'b0;
        for (int i = 0; i < 17; i++) v[i] = rand_val(i < 16 ? TMAX : SMAX);
        v[0] = 3;
        send_frame(v, 1'b1);
        model(v);
        expect_commit("start_wins");

        // Reset mid-frame.
        pulse_start();
        send_str("11 22 3");
        #2 rst = 1'b1;
        #1;
        check("midrst/board", board, '0);
        check("midrst/score", score, '0);
        check("midrst/busy",  busy,  1'b0);
        check("midrst/error", error, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cnt = done_cnt;
        for (int i = 0; i < 17; i++) v[i] = int'($urandom_range(1, 900));
        send_frame(v, 1'b1);
        @(negedge clk);
        check("midrst/ignored_busy",  busy, 1'b0);
        check("midrst/ignored_board", board, '0);
        check("midrst/ignored_done",  done_cnt - cnt, 0);

        // Randomized frames.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 17; i++) v[i] = rand_val(i < 16 ? TMAX : SMAX);
            pulse_start();
            send_frame(v, 1'b1);
            model(v);
            expect_commit($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
